text_writer: RTL and testbench

Character-stream writer for the 80x25 text buffer scanned out by the text video adapter. Accepts bytes over a valid/ready handshake, writes character/attribute pairs into video memory, interprets control codes, scrolls and clears the screen. Drives the cursor index the adapter uses for the blinking underline. Sits between the CPU/UART byte source and the video memory write port.

---
 rtl/text_writer.sv | 171 +++++++++++++++++
 tb/tb_text_writer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_writer.sv
// Character-stream writer for an 80x25 text buffer: prints bytes as char/attribute
// pairs, interprets CR/LF/BS/FF, scrolls through a synchronous RAM and clears the screen.
module text_writer #(
    parameter int         COLS  = 80,
    parameter int         ROWS  = 25,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  attr,
    output logic [12:0] address,
    output logic [7:0]  wdata,
    output logic        we,
    input  logic [7:0]  rdata,
    output logic [10:0] cursor
);

    localparam logic [10:0] COLS_C    = 11'(COLS);
    localparam logic [10:0] LAST_CELL = 11'(COLS * ROWS - 1);
    localparam logic [10:0] LAST_ROW  = 11'(COLS * (ROWS - 1));
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [11:0] ROW_BYTES = 12'(2 * COLS);
    localparam logic [11:0] LAST_BYTE = 12'(2 * COLS * ROWS - 1);
    localparam logic [11:0] FILL_BASE = 12'(2 * COLS * (ROWS - 1));

    typedef enum logic [2:0] {IDLE, PUT_AT, SCR_RD, SCR_WT, SCR_WR, FILL, CLR} state_t;

    state_t      state_q, state_d;
    logic [10:0] cursor_q, cursor_d;
    logic [6:0]  col_q, col_d;
    logic [11:0] ptr_q, ptr_d;
    logic        phase_q, phase_d;
    logic [7:0]  ch_q, ch_d;
    logic [7:0]  attr_q, attr_d;
    logic [7:0]  rbuf_q, rbuf_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cursor_q <= '0;
            col_q    <= '0;
            ptr_q    <= '0;
            phase_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            col_q    <= col_d;
            ptr_q    <= ptr_d;
            phase_q  <= phase_d;
        end
    end

    always_ff @(posedge clock) begin
        ch_q   <= ch_d;
        attr_q <= attr_d;
        rbuf_q <= rbuf_d;
    end

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        col_d    = col_q;
        ptr_d    = ptr_q;
        phase_d  = phase_q;
        ch_d     = ch_q;
        attr_d   = attr_q;
        rbuf_d   = rbuf_q;
        in_ready = 1'b0;
        address  = '0;
        wdata    = '0;
        we       = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ch_d   = in_data;
                    attr_d = attr;
                    if (in_data >= 8'h20) begin
                        state_d = PUT_AT;
                        phase_d = 1'b0;
                    end else begin
                        case (in_data)
                            8'h0D: begin
                                cursor_d = cursor_q - {4'b0, col_q};
                                col_d    = '0;
                            end
                            8'h0A: begin
                                if (cursor_q >= LAST_ROW) begin
                                    state_d = SCR_RD;
                                    ptr_d   = ROW_BYTES;
                                end else begin
                                    cursor_d = cursor_q - {4'b0, col_q} + COLS_C;
                                    col_d    = '0;
                                end
                            end
                            8'h08: begin
                                if (col_q != '0) begin
                                    cursor_d = cursor_q - 11'd1;
                                    col_d    = col_q - 7'd1;
                                end
                            end
                            8'h0C: begin
                                state_d = CLR;
                                ptr_d   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            // Two write cycles: char at 2c, then attribute at 2c+1.
            PUT_AT: begin
                we      = 1'b1;
                address = {1'b0, cursor_q, phase_q};
                wdata   = phase_q ? attr_q : ch_q;
                phase_d = 1'b1;
                if (phase_q) begin
                    if (cursor_q == LAST_CELL) begin
                        state_d = SCR_RD;
                        ptr_d   = ROW_BYTES;
                    end else begin
                        state_d  = IDLE;
                        cursor_d = cursor_q + 11'd1;
                        col_d    = (col_q == LAST_COL) ? 7'd0 : col_q + 7'd1;
                    end
                end
            end
            SCR_RD: begin
                address = {1'b0, ptr_q};
                state_d = SCR_WT;
            end
            // Address held so the RAM output stays stable; it is captured at this edge.
            SCR_WT: begin
                address = {1'b0, ptr_q};
                rbuf_d  = rdata;
                state_d = SCR_WR;
            end
            SCR_WR: begin
                we      = 1'b1;
                address = {1'b0, ptr_q - ROW_BYTES};
                wdata   = rbuf_q;
                if (ptr_q == LAST_BYTE) begin
                    state_d = FILL;
                    ptr_d   = FILL_BASE;
                end else begin
                    ptr_d   = ptr_q + 12'd1;
                    state_d = SCR_RD;
                end
            end
            FILL, CLR: begin
                we      = 1'b1;
                address = {1'b0, ptr_q};
                wdata   = ptr_q[0] ? attr_q : BLANK;
                ptr_d   = ptr_q + 12'd1;
                if (ptr_q == LAST_BYTE) begin
                    state_d  = IDLE;
                    cursor_d = (state_q == FILL) ? LAST_ROW : 11'd0;
                    col_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cursor = cursor_q;

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: a RAM model, a write scoreboard fed by a cursor
// model, and direct checks of cursor/handshake timing.
module tb_text_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  attr_in = 8'h00;
    logic [12:0] address;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  rdata;
    logic [10:0] cursor;

    text_writer dut (
        .clock   (clock),
        .reset   (reset),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .attr    (attr_in),
        .address (address),
        .wdata   (wdata),
        .we      (we),
        .rdata   (rdata),
        .cursor  (cursor)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [4096];
    logic       preload = 1'b0;

    always @(posedge clock) begin
        if (preload) begin
            for (int k = 0; k < 3840; k++) mem[160 + k] <= 8'(k);
        end else if (we) begin
            mem[address[11:0]] <= wdata;
        end
        rdata <= mem[address[11:0]];
    end

    int          checks = 0;
    int          errors = 0;
    int          model_cur = 0;
    logic [7:0]  exp_mem [4096];
    logic [20:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int a, input logic [7:0] d);
        sb.push_back({13'(a), d});
        exp_mem[a] = d;
    endtask

    task automatic push_scroll(input logic [7:0] a);
        for (int k = 0; k < 3840; k++) push(k, exp_mem[k + 160]);
        for (int k = 3840; k < 4000; k++) push(k, (k % 2 == 1) ? a : 8'h20);
    endtask

    task automatic model(input logic [7:0] b, input logic [7:0] a);
        int col;
        col = model_cur % 80;
        if (b >= 8'h20) begin
            push(2 * model_cur, b);
            push(2 * model_cur + 1, a);
            if (model_cur == 1999) begin
                push_scroll(a);
                model_cur = 1920;
            end else model_cur++;
        end else if (b == 8'h0D) model_cur -= col;
        else if (b == 8'h0A) begin
            if (model_cur >= 1920) begin
                push_scroll(a);
                model_cur = 1920;
            end else model_cur = model_cur - col + 80;
        end else if (b == 8'h08) begin
            if (col > 0) model_cur--;
        end else if (b == 8'h0C) begin
            for (int k = 0; k < 4000; k++) push(k, (k % 2 == 1) ? a : 8'h20);
            model_cur = 0;
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 20000) begin
            @(posedge clock); #1;
            n++;
        end
        chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] a);
        wait_ready();
        model(b, a);
        in_data  = b;
        attr_in  = a;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        sb.delete();
        model_cur = 0;
    endtask

    initial begin
        int n;
        int wc;
        fork
            forever begin
                @(negedge clock);
                if (!reset && we) begin
                    if (sb.size() == 0)
                        chk("unexpected_write", {11'd0, address, wdata}, 32'hFFFF_FFFF);
                    else
                        chk("write", {11'd0, address, wdata}, {11'd0, sb.pop_front()});
                end
            end
        join_none

        // Reset values
        do_reset();
        chk("rst_address", {19'd0, address}, 32'd0);
        chk("rst_wdata", {24'd0, wdata}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_cursor", {21'd0, cursor}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);

        // Single printable
        send(8'h41, 8'h1F);
        chk("A_addr0", {19'd0, address}, 32'd0);
        chk("A_data0", {24'd0, wdata}, 32'h41);
        chk("A_we0", {31'd0, we}, 32'd1);
        @(posedge clock); #1;
        chk("A_addr1", {19'd0, address}, 32'd1);
        chk("A_data1", {24'd0, wdata}, 32'h1F);
        chk("A_ready_busy", {31'd0, in_ready}, 32'd0);
        @(posedge clock); #1;
        chk("A_cursor", {21'd0, cursor}, 32'd1);
        chk("A_ready", {31'd0, in_ready}, 32'd1);
        chk("A_we_off", {31'd0, we}, 32'd0);

        // Line wrap, CR, BS
        do_reset();
        for (int i = 0; i < 80; i++) send(8'h61, 8'h07);
        wait_ready();
        chk("cur80", {21'd0, cursor}, 32'd80);
        send(8'h61, 8'h07);
        wait_ready();
        chk("cur81", {21'd0, cursor}, 32'd81);
        send(8'h0D, 8'h07);
        @(posedge clock); #1;
        chk("cr_cursor", {21'd0, cursor}, 32'd80);
        chk("cr_ready", {31'd0, in_ready}, 32'd1);
        send(8'h08, 8'h07);
        @(posedge clock); #1;
        chk("bs_col0", {21'd0, cursor}, 32'd80);
        send(8'h61, 8'h07);
        send(8'h08, 8'h07);
        @(posedge clock); #1;
        chk("bs_col1", {21'd0, cursor}, 32'd80);
        chk("bs_model", {21'd0, cursor}, 32'(model_cur));

        // Form feed from cursor 1234
        do_reset();
        for (int i = 0; i < 15; i++) send(8'h0A, 8'h07);
        for (int i = 0; i < 34; i++) send(8'h63, 8'h07);
        wait_ready();
        chk("cur1234", {21'd0, cursor}, 32'd1234);
        send(8'h0C, 8'h4E);
        n  = 0;
        wc = 0;
        while (!in_ready && n < 5000) begin
            if (we) wc++;
            @(posedge clock); #1;
            n++;
        end
        chk("ff_we_cycles", 32'(wc), 32'd4000);
        chk("ff_cursor", {21'd0, cursor}, 32'd0);
        chk("ff_sb_empty", 32'(sb.size()), 32'd0);

        // Scroll triggered by printing at cell 1999, in_valid held during it
        do_reset();
        for (int i = 0; i < 24; i++) send(8'h0A, 8'h07);
        for (int i = 0; i < 79; i++) send(8'h78, 8'h07);
        wait_ready();
        chk("cur1999", {21'd0, cursor}, 32'd1999);
        preload = 1'b1;
        @(posedge clock); #1;
        preload = 1'b0;
        for (int k = 0; k < 3840; k++) exp_mem[160 + k] = 8'(k);
        model(8'h5A, 8'h07);
        in_data  = 8'h5A;
        attr_in  = 8'h07;
        in_valid = 1'b1;
        @(posedge clock); #1;
        n = 0;
        while (!in_ready && n < 12000) begin
            in_data = 8'($urandom);
            attr_in = 8'($urandom);
            n++;
            @(posedge clock); #1;
        end
        in_data = 8'h01;
        chk("scroll_busy", 32'(n), 32'd11682);
        chk("scroll_cursor", {21'd0, cursor}, 32'd1920);
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("ign_cursor", {21'd0, cursor}, 32'd1920);
        chk("ign_ready", {31'd0, in_ready}, 32'd1);
        chk("ign_we", {31'd0, we}, 32'd0);
        in_valid = 1'b0;
        chk("scroll_sb_empty", 32'(sb.size()), 32'd0);
        chk("mem0", {24'd0, mem[0]}, 32'h00);
        chk("mem255", {24'd0, mem[255]}, 32'hFF);
        chk("mem3837", {24'd0, mem[3837]}, 32'hFD);
        chk("mem3838", {24'd0, mem[3838]}, 32'h5A);
        chk("mem3839", {24'd0, mem[3839]}, 32'h07);
        chk("mem3840", {24'd0, mem[3840]}, 32'h20);
        chk("mem3999", {24'd0, mem[3999]}, 32'h07);

        // Reset in the middle of an LF-triggered scroll
        send(8'h0A, 8'h07);
        repeat (5000) begin
            @(posedge clock); #1;
        end
        chk("mid_busy", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        sb.delete();
        model_cur = 0;
        chk("abort_we", {31'd0, we}, 32'd0);
        chk("abort_cursor", {21'd0, cursor}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        send(8'h42, 8'h1E);
        chk("B_addr0", {19'd0, address}, 32'd0);
        @(posedge clock); #1;
        chk("B_addr1", {19'd0, address}, 32'd1);
        wait_ready();
        chk("B_cursor", {21'd0, cursor}, 32'd1);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
